// File: rtl/mul_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl_pkg
// Shared definitions for the repeated-addition multiplier control path.
//   DEFAULT_WIDTH : default datapath / iteration-counter width
//   state_t       : controller state encoding (3-bit)
// ---------------------------------------------------------------------------
package mul_seq_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
// Control FSM for a repeated-addition multiplier datapath. Operands A and B
// arrive one after the other on a shared bus (valid/ready). The controller
// then adds A into P once per remaining count of B. It finishes with a
// valid/ready handshake toward the consumer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new multiply (sampled in IDLE only)
//   in_valid   upstream operand valid on the datapath bus
//   in_ready   controller accepts the operand this cycle
//   eqz        B counter is zero
//   ld_a       load A register from bus
//   ld_b       load B counter from bus
//   dec_b      decrement B counter
//   clr_p      synchronous clear of P
//   ld_p       P <= P + A
//   busy       high in every state except IDLE
//   out_valid  product on P is final
//   out_ready  downstream accepts the product
//   iter_cnt   additions performed in the current/last operation (saturating)
// ---------------------------------------------------------------------------
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eqz,
  output logic             ld_a,
  output logic             ld_b,
  output logic             dec_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] iter_cnt
);

  state_t state;

  // State register and iteration counter. The counter is cleared when a new
  // operation is accepted. It is held at all-ones instead of wrapping, so a
  // monitor can never see a long run that looks like a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_A;
            iter_cnt <= '0;
          end
        end
        LOAD_A: begin
          if (in_valid) state <= LOAD_B;
        end
        LOAD_B: begin
          if (in_valid) state <= CALC;
        end
        CALC: begin
          if (eqz) begin
            state <= DONE;
          end else if (iter_cnt != {WIDTH{1'b1}}) begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded straight from state and inputs so the datapath acts
  // on the same edge the FSM moves on. P is cleared together with the B load.
  // Stale P from an aborted operation therefore never leaks into a new product.
  always_comb begin
    in_ready  = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    dec_b     = 1'b0;
    clr_p     = 1'b0;
    ld_p      = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        ld_a     = in_valid;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        ld_b     = in_valid;
        clr_p    = in_valid;
      end
      CALC: begin
        ld_p  = ~eqz;
        dec_b = ~eqz;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_ctrl
// Directed bench for mul_seq_ctrl. The bench carries a behavioural model of
// the A/B/P datapath that reacts to the controller strobes. Expected products,
// iteration counts and latencies are hand-computed constants. A second,
// narrow instance exercises iteration-counter saturation.
// ---------------------------------------------------------------------------
module tb_mul_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] bus = '0;
  logic         in_ready, eqz, ld_a, ld_b, dec_b, clr_p, ld_p, busy, out_valid;
  logic [W-1:0] iter_cnt;

  logic [W-1:0] reg_a = '0;
  logic [W-1:0] reg_b = '0;
  logic [W-1:0] reg_p = '0;

  // narrow instance used only for the saturation corner
  logic       s_start = 1'b0;
  logic       s_in_valid = 1'b0;
  logic       s_eqz = 1'b0;
  logic       s_out_ready = 1'b0;
  logic       s_in_ready, s_ld_a, s_ld_b, s_dec_b, s_clr_p, s_ld_p, s_busy, s_out_valid;
  logic [3:0] s_iter_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_p;
    logic [W-1:0] exp_iter;
    int           exp_lat;
    int           exp_ldp;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .eqz(eqz), .ld_a(ld_a), .ld_b(ld_b), .dec_b(dec_b),
    .clr_p(clr_p), .ld_p(ld_p), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .iter_cnt(iter_cnt)
  );

  mul_seq_ctrl #(.WIDTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .eqz(s_eqz), .ld_a(s_ld_a), .ld_b(s_ld_b),
    .dec_b(s_dec_b), .clr_p(s_clr_p), .ld_p(s_ld_p), .busy(s_busy),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .iter_cnt(s_iter_cnt)
  );

  // Behavioural datapath: PIPO1 (A), CNTR (B), PIPO2 (P), ADD and EQZ.
  // It has no reset, so registers keep stale contents across a controller reset.
  always @(posedge clk) begin
    if (ld_a) reg_a <= bus;
    if (ld_b) reg_b <= bus;
    else if (dec_b) reg_b <= reg_b - 1'b1;
    if (clr_p) reg_p <= '0;
    else if (ld_p) reg_p <= reg_p + reg_a;
  end

  assign eqz = (reg_b == '0);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Mutually exclusive strobe pairs, checked every cycle
  always @(negedge clk) begin
    checkOutput("excl_clr_ld_p", {31'b0, clr_p & ld_p}, 32'd0);
    checkOutput("excl_ld_dec_b", {31'b0, ld_b & dec_b}, 32'd0);
  end

  // Waits for out_valid with a cycle budget; called right after an edge.
  task automatic waitOutValid(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'b0, out_valid}, 32'd1);
  endtask

  // One full zero-stall operation with out_ready held high. lat counts edges
  // after the start-sampling edge until out_valid is seen.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat, output int ldp,
                               output logic [W-1:0] p, output logic [W-1:0] it);
    lat = 0;
    ldp = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    bus = a;
    @(posedge clk); #1;
    lat++;
    bus = b;
    @(posedge clk); #1;
    lat++;
    bus = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (ld_p) ldp++;
      if (out_valid || lat > 1000) break;
      @(posedge clk); #1;
      lat++;
    end
    p = reg_p;
    it = iter_cnt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           lat, ldp, nla, nlb, nclr;
    logic [W-1:0] p, it;

    vecs[0] = '{a: 16'd5,     b: 16'd3,   exp_p: 16'd15,    exp_iter: 16'd3,   exp_lat: 6,   exp_ldp: 3};
    vecs[1] = '{a: 16'd7,     b: 16'd0,   exp_p: 16'd0,     exp_iter: 16'd0,   exp_lat: 3,   exp_ldp: 0};
    vecs[2] = '{a: 16'd300,   b: 16'd300, exp_p: 16'd24464, exp_iter: 16'd300, exp_lat: 303, exp_ldp: 300};
    vecs[3] = '{a: 16'd0,     b: 16'd4,   exp_p: 16'd0,     exp_iter: 16'd4,   exp_lat: 7,   exp_ldp: 4};
    vecs[4] = '{a: 16'd65535, b: 16'd2,   exp_p: 16'd65534, exp_iter: 16'd2,   exp_lat: 5,   exp_ldp: 2};

    // reset state
    #3;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_strobes", {26'b0, ld_a, ld_b, dec_b, clr_p, ld_p, out_valid}, 32'd0);
    checkOutput("rst_iter_cnt", {16'b0, iter_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven zero-stall operations
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat, ldp, p, it);
      checkOutput($sformatf("vec%0d_p", i), {16'b0, p}, {16'b0, vecs[i].exp_p});
      checkOutput($sformatf("vec%0d_iter", i), {16'b0, it}, {16'b0, vecs[i].exp_iter});
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_ld_p_pulses", i), ldp, vecs[i].exp_ldp);
    end

    // stalls on both operands, then back-pressure in DONE (A=9, B=2)
    nla = 0; nlb = 0; nclr = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    bus = 16'd9;
    repeat (4) begin
      @(negedge clk);
      nla += int'(ld_a);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    @(negedge clk);
    nla += int'(ld_a);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bus = 16'd2;
    repeat (2) begin
      @(negedge clk);
      nlb += int'(ld_b);
      nclr += int'(clr_p);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    @(negedge clk);
    nlb += int'(ld_b);
    nclr += int'(clr_p);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("stall_ld_a_pulses", nla, 32'd1);
    checkOutput("stall_ld_b_pulses", nlb, 32'd1);
    checkOutput("stall_clr_p_pulses", nclr, 32'd1);
    waitOutValid("stall_out_valid_timeout", 50);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_busy", {31'b0, busy}, 32'd1);
      checkOutput("bp_p", {16'b0, reg_p}, 32'd18);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_idle_after_ready", {31'b0, busy}, 32'd0);

    // reset mid-CALC after three iterations (A=4, B=10)
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    bus = 16'd4;
    @(posedge clk); #1;
    bus = 16'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midcalc_iter", {16'b0, iter_cnt}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_strobes", {26'b0, ld_a, ld_b, dec_b, clr_p, ld_p, in_ready}, 32'd0);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_iter", {16'b0, iter_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd2, 16'd2, lat, ldp, p, it);
    checkOutput("after_rst_p", {16'b0, p}, 32'd4);
    checkOutput("after_rst_iter", {16'b0, it}, 32'd2);

    // start pulses during CALC and DONE are ignored (A=3, B=4)
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    bus = 16'd3;
    @(posedge clk); #1;
    bus = 16'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitOutValid("ign_out_valid_timeout", 50);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("ign_done_hold", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ign_p", {16'b0, reg_p}, 32'd12);
    checkOutput("ign_iter", {16'b0, iter_cnt}, 32'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("ign_idle0", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("ign_idle1", {31'b0, busy}, 32'd0);

    // start held continuously: one IDLE cycle between operations (A=2, B=1)
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    bus = 16'd2;
    @(posedge clk); #1;
    bus = 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOutValid("held_out_valid_timeout", 50);
    checkOutput("held_p", {16'b0, reg_p}, 32'd2);
    @(negedge clk);
    checkOutput("held_idle_gap", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("held_restart", {31'b0, busy}, 32'd1);
    start = 1'b0;
    in_valid = 1'b1;
    bus = 16'd0;
    begin
      int n = 0;
      while (busy && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("held_drain", {31'b0, busy}, 32'd0);

    // iteration counter saturation on the 4-bit instance
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_iter", {28'b0, s_iter_cnt}, 32'd15);
    checkOutput("sat_busy", {31'b0, s_busy}, 32'd1);
    s_eqz = 1'b1;
    s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_iter_final", {28'b0, s_iter_cnt}, 32'd15);
    checkOutput("sat_idle", {31'b0, s_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Control-path FSM for the 16-bit repeated-addition multiplier datapath: operand registers PIPO1 (A) and CNTR (B), accumulator PIPO2 (P), ADD and EQZ.
- Accepts two operands in sequence from an upstream producer over a shared 16-bit bus with a valid/ready handshake.
- Drives the datapath load, clear and decrement strobes, and consumes eqz.
- Presents completion to a downstream consumer with a valid/ready handshake, plus an iteration count for performance monitoring.

Parameters:
- WIDTH, 16, datapath and iteration-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new multiply; sampled only in IDLE.
- in_valid  input  1  upstream operand on the datapath bus is valid.
- in_ready  output  1  controller accepts the operand this cycle.
- eqz  input  1  EQZ output on the B counter value.
- ld_a  output  1  load strobe to the A register.
- ld_b  output  1  load strobe to the B counter.
- dec_b  output  1  decrement strobe to the B counter.
- clr_p  output  1  synchronous clear to the P register.
- ld_p  output  1  load strobe to the P register (P <= P + A).
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  product on P is final.
- out_ready  input  1  downstream accepts the product.
- iter_cnt  output  WIDTH  additions performed in the current or last operation.

Behaviour:
- Reset: rst_n low forces, asynchronously, state=IDLE and iter_cnt=0. All strobes, in_ready, busy and out_valid are 0 while rst_n is low.
- Outputs: all strobes are Moore/Mealy combinational from state and inputs, with no registered delay. Only state and iter_cnt are flops.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD_A; iter_cnt cleared to 0 on the same edge.
- LOAD_A:
  - in_ready=1; ld_a = in_valid.
  - in_valid=1 -> LOAD_B; otherwise stay (wait indefinitely).
- LOAD_B:
  - in_ready=1; ld_b = in_valid; clr_p = in_valid.
  - in_valid=1 -> CALC; otherwise stay.
- CALC: eqz is evaluated every cycle against the registered B.
  - eqz=0: ld_p=1, dec_b=1, iter_cnt += 1, stay in CALC.
  - eqz=1: no strobes -> DONE.
  - Result: exactly B additions, and CALC lasts B+1 cycles.
- DONE:
  - out_valid=1; hold until out_ready=1, then -> IDLE.
  - P, A and B are not touched while in DONE.
- Latency: start to out_valid = 3 + B cycles, with zero upstream stall.
- Boundaries:
  - B=0: CALC lasts 1 cycle, P=0, iter_cnt=0.
  - A=0: B iterations still run, P=0.
  - Product overflow wraps modulo 2^WIDTH. This is the datapath's behaviour; the controller does not flag it.
  - iter_cnt saturates at all-ones and never wraps.
  - start while busy=1 is ignored, with no queuing.
  - start held high through DONE begins a new operation only after the return to IDLE (one IDLE cycle minimum).
  - in_valid in IDLE, CALC or DONE is ignored (in_ready=0).
  - out_ready outside DONE is ignored.
  - clr_p and ld_p are never asserted together. ld_b and dec_b are never asserted together.
  - Reset mid-operation: immediate return to IDLE. Datapath registers keep their contents but are treated as stale; the next LOAD_B clears P.

Decomposition:
- Shared package holds:
  - state encoding enum: IDLE=0, LOAD_A=1, LOAD_B=2, CALC=3, DONE=4, 3-bit;
  - WIDTH default constant.
- Single module.
- Optional top-level wrapper mul_seq_top instantiates mul_seq_ctrl together with PIPO1, PIPO2, CNTR, ADD and EQZ for system tests.

Test Plan:
1. A=5, B=3, no stalls, out_ready=1: out_valid 6 cycles after start; P=15; iter_cnt=3; ld_p pulses exactly 3 times.
2. A=7, B=0: CALC 1 cycle; P=0; iter_cnt=0; ld_p never asserted; out_valid 3 cycles after start.
3. A=300, B=300: P=90000 mod 65536=24464; iter_cnt=300.
4. A=9, B=2, in_valid withheld 4 cycles in LOAD_A and 2 cycles in LOAD_B: ld_a/ld_b fire only on the valid cycles; P=18. Then out_ready low 5 cycles: out_valid held, P stable at 18, busy=1; IDLE the cycle after out_ready=1.
5. rst_n pulsed low mid-CALC (A=4, B=10, after 3 iterations): outputs 0 immediately; state IDLE. New start with A=2, B=2 -> P=4 (stale P cleared).
6. start pulsed during CALC and DONE: ignored; start held continuously: operations separated by at least one IDLE cycle with busy=0.
